render_sequencer: RTL and testbench
===================================

Name: render_sequencer

Overview:
- Frame-level controller for the isometric tile raster engine, which draws one square at a time.
- On each frame_start it snapshots up to three square descriptors and orders them back-to-front by center_y (painter's order).
- It commands a buffer clear, then issues one draw command per valid square over a valid/ready handshake, waiting for the engine's done pulse after each.
- Sits between game logic (descriptor source) and the raster engine; reports frame completion and engine-timeout errors.

Parameters:
- SQ_WIDTH, 41: descriptor width. Fields: cx [7:0], cy [15:8], r [23:16], h [31:24], c1 [34:32], c2 [37:35], c3 [40:38].
- TIMEOUT, 65535: max cycles to wait for eng_done after a command is accepted.
- TO_W, 16: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse requesting a new frame.
- square1, square2, square3  in  SQ_WIDTH  tile descriptors, sampled only on an accepted frame_start.
- sq_en  in  3  per-square enable; bit i corresponds to square(i+1).
- cmd_valid  out  1  command offered to the engine.
- cmd_ready  in  1  engine accepts the command when cmd_valid && cmd_ready.
- cmd_op  out  1  0 = clear buffer, 1 = draw square.
- cmd_square  out  SQ_WIDTH  descriptor for a draw; all zero for a clear.
- eng_done  in  1  one-cycle pulse when the engine finishes the accepted command.
- busy  out  1  high from accepted frame_start until frame_done/abort.
- frame_done  out  1  one-cycle pulse when the frame completes normally.
- timeout_err  out  1  sticky; set on engine timeout, cleared only by rst or the next accepted frame_start.
- overrun  out  1  one-cycle pulse when frame_start arrives while busy.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; cmd_valid=0, cmd_op=0, cmd_square=0, busy=0, frame_done=0, timeout_err=0, overrun=0; snapshot regs, draw list and counters cleared. An in-flight command is abandoned with no further outputs.
- States: IDLE, SORT, CLEAR, CLEAR_WAIT, ISSUE, DRAW_WAIT, DONE.
- IDLE: on frame_start, latch square1..3 and sq_en, clear timeout_err, set busy (visible next cycle), go to SORT.
- SORT: one cycle. Build a list of enabled squares with r != 0.
  - Order by cy ascending; ties keep index order (1 before 2 before 3).
  - Store count N (0..3) and go to CLEAR.
- CLEAR: assert cmd_valid, cmd_op=0, cmd_square=0. Hold these stable until the handshake.
  - On handshake: drop cmd_valid next cycle, reset the timeout counter, go to CLEAR_WAIT.
- CLEAR_WAIT: on eng_done, go to ISSUE if N>0, else DONE.
- ISSUE: assert cmd_valid, cmd_op=1, cmd_square=list[k] (k starts at 0). Hold stable until the handshake, then go to DRAW_WAIT.
- DRAW_WAIT: on eng_done, k=k+1. Go to ISSUE if k<N, else DONE.
- DONE: pulse frame_done for one cycle, deassert busy, return to IDLE. A frame_start in this cycle is an overrun.
- Timeout: in CLEAR_WAIT and DRAW_WAIT the counter increments each cycle.
  - When the count reaches TIMEOUT without eng_done: set timeout_err, skip remaining commands, go to IDLE with busy=0 and no frame_done.
  - eng_done in the same cycle as the counter reaching TIMEOUT counts as success.
- eng_done outside a WAIT state is ignored.
- frame_start while busy (any state except IDLE): ignored, overrun pulses in that cycle, the current frame is unaffected.
- Latency: frame_start to first cmd_valid is exactly 2 cycles (IDLE -> SORT -> CLEAR). From eng_done to the next cmd_valid is 1 cycle.
- Descriptor inputs may change freely while busy; only the snapshot is used.

Test Plan:
- Sort and issue order: sq_en=3'b111, cy = 40, 10, 25 for square1..3 (all r=5) -> clear, then draws in order sq2, sq3, sq1; engine done after 4 cycles each; one frame_done; busy low afterwards.
- Tie and skip: cy = 20, 20, 5; square3 r=0; sq_en=3'b111 -> clear, then sq1, sq2 only; N=2.
- Backpressure: cmd_ready held low 7 cycles on the clear and on each draw -> cmd_valid, cmd_op and cmd_square stay constant across the stall; exactly one handshake per command.
- Empty frame: sq_en=0 -> only the clear command is issued, then frame_done.
- Timeout: TIMEOUT=20, engine never pulses done after the second command -> timeout_err=1 at wait cycle 20, busy=0, no frame_done. The next frame_start clears timeout_err and the frame completes normally.
- Overrun and async reset: frame_start during DRAW_WAIT -> overrun pulse, frame unaffected. rst asserted mid-ISSUE -> all outputs zero immediately without a clock edge; a post-reset frame runs normally.

Source files
------------

// File: rtl/render_sequencer_if.sv
// Command bus between the render sequencer and the tile raster engine.
// The sequencer drives the command. The engine answers with ready and a done pulse.
interface render_sequencer_if #(
    parameter int unsigned SQ_WIDTH = 41
) ();
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_op;
    logic [SQ_WIDTH-1:0] cmd_square;
    logic                eng_done;

    modport master (
        output cmd_valid, cmd_op, cmd_square,
        input  cmd_ready, eng_done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_square,
        output cmd_ready, eng_done
    );
endinterface

// File: rtl/render_sequencer.sv
// Frame controller for the raster engine. It snapshots up to three squares and orders them back-to-front by cy.
// It issues a buffer clear, then one draw per square, and waits for the engine's done pulse after each command.
module render_sequencer #(
    parameter int unsigned SQ_WIDTH = 41,
    parameter int unsigned TIMEOUT  = 65535,
    parameter int unsigned TO_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_start,
    input  logic [SQ_WIDTH-1:0] square1,
    input  logic [SQ_WIDTH-1:0] square2,
    input  logic [SQ_WIDTH-1:0] square3,
    input  logic [2:0]          sq_en,
    render_sequencer_if.master  eng,
    output logic                busy,
    output logic                frame_done,
    output logic                timeout_err,
    output logic                overrun
);
    localparam int unsigned NSQ    = 3;
    localparam int unsigned FW     = 8;
    localparam int unsigned CY_LSB = 8;
    localparam int unsigned R_LSB  = 16;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, SORT, CLEAR, CLEAR_WAIT, ISSUE, DRAW_WAIT, DONE
    } state_t;

    state_t              state_q, state_d;
    logic [SQ_WIDTH-1:0] snap_q [NSQ];
    logic [SQ_WIDTH-1:0] snap_d [NSQ];
    logic [SQ_WIDTH-1:0] list_q [NSQ];
    logic [SQ_WIDTH-1:0] list_d [NSQ];
    logic [NSQ-1:0]      en_q, en_d;
    logic [1:0]          n_q, n_d, k_q, k_d;
    logic [TO_W-1:0]     cnt_q, cnt_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic                cmd_op_q, cmd_op_d;
    logic [SQ_WIDTH-1:0] cmd_square_q, cmd_square_d;
    logic                busy_d, frame_done_d, timeout_err_d, overrun_d;
    logic [NSQ-1:0]      live;
    logic [1:0]          pos;
    logic                hs;

    assign eng.cmd_valid  = cmd_valid_q;
    assign eng.cmd_op     = cmd_op_q;
    assign eng.cmd_square = cmd_square_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            for (int i = 0; i < NSQ; i++) begin
                snap_q[i] <= '0;
                list_q[i] <= '0;
            end
            en_q         <= '0;
            n_q          <= '0;
            k_q          <= '0;
            cnt_q        <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_op_q     <= 1'b0;
            cmd_square_q <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            timeout_err  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            list_q       <= list_d;
            en_q         <= en_d;
            n_q          <= n_d;
            k_q          <= k_d;
            cnt_q        <= cnt_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_op_q     <= cmd_op_d;
            cmd_square_q <= cmd_square_d;
            busy         <= busy_d;
            frame_done   <= frame_done_d;
            timeout_err  <= timeout_err_d;
            overrun      <= overrun_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        snap_d        = snap_q;
        list_d        = list_q;
        en_d          = en_q;
        n_d           = n_q;
        k_d           = k_q;
        cnt_d         = cnt_q;
        cmd_valid_d   = cmd_valid_q;
        cmd_op_d      = cmd_op_q;
        cmd_square_d  = cmd_square_q;
        busy_d        = busy;
        frame_done_d  = 1'b0;
        timeout_err_d = timeout_err;
        overrun_d     = frame_start && (state_q != IDLE);
        live          = '0;
        pos           = '0;
        hs            = cmd_valid_q && eng.cmd_ready;

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    snap_d[0]     = square1;
                    snap_d[1]     = square2;
                    snap_d[2]     = square3;
                    en_d          = sq_en;
                    timeout_err_d = 1'b0;
                    busy_d        = 1'b1;
                    state_d       = SORT;
                end
            end
            SORT: begin
                // Each live square's slot equals the number of live squares ahead of it (smaller cy, or equal cy at a lower index).
                for (int i = 0; i < NSQ; i++)
                    live[i] = en_q[i] && (snap_q[i][R_LSB +: FW] != '0);
                n_d = '0;
                for (int i = 0; i < NSQ; i++) begin
                    if (live[i]) begin
                        pos = '0;
                        for (int j = 0; j < NSQ; j++) begin
                            if ((j != i) && live[j] &&
                                ((snap_q[j][CY_LSB +: FW] < snap_q[i][CY_LSB +: FW]) ||
                                 ((snap_q[j][CY_LSB +: FW] == snap_q[i][CY_LSB +: FW]) && (j < i))))
                                pos = pos + 2'd1;
                        end
                        list_d[pos] = snap_q[i];
                        n_d         = n_d + 2'd1;
                    end
                end
                k_d          = '0;
                cmd_valid_d  = 1'b1;
                cmd_op_d     = 1'b0;
                cmd_square_d = '0;
                state_d      = CLEAR;
            end
            CLEAR, ISSUE: begin
                if (hs) begin
                    cmd_valid_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = (state_q == CLEAR) ? CLEAR_WAIT : DRAW_WAIT;
                end
            end
            CLEAR_WAIT, DRAW_WAIT: begin
                // A done pulse in the same cycle as the last allowed count still counts as success.
                if (eng.eng_done) begin
                    if (state_q == CLEAR_WAIT) begin
                        k_d = '0;
                        if (n_q != '0) begin
                            cmd_valid_d  = 1'b1;
                            cmd_op_d     = 1'b1;
                            cmd_square_d = list_q[0];
                            state_d      = ISSUE;
                        end else begin
                            frame_done_d = 1'b1;
                            busy_d       = 1'b0;
                            state_d      = DONE;
                        end
                    end else begin
                        k_d = k_q + 2'd1;
                        if ((k_q + 2'd1) < n_q) begin
                            cmd_valid_d  = 1'b1;
                            cmd_op_d     = 1'b1;
                            cmd_square_d = list_q[k_q + 2'd1];
                            state_d      = ISSUE;
                        end else begin
                            frame_done_d = 1'b1;
                            busy_d       = 1'b0;
                            state_d      = DONE;
                        end
                    end
                end else if (cnt_q == TO_LAST) begin
                    timeout_err_d = 1'b1;
                    busy_d        = 1'b0;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_render_sequencer.sv
// Scoreboard bench for render_sequencer: a behavioural engine pops the expected commands.
// A painter's-order model pushes those commands when each frame starts.
module tb_render_sequencer;
    localparam int unsigned SQW = 41;
    localparam int unsigned TMO = 20;
    localparam int unsigned TOW = 16;
    localparam int          LIMIT = 2000;

    typedef struct packed {
        logic           op;
        logic [SQW-1:0] sq;
    } cmd_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           frame_start;
    logic [SQW-1:0] square1, square2, square3;
    logic [2:0]     sq_en;
    logic           busy, frame_done, timeout_err, overrun;

    render_sequencer_if #(.SQ_WIDTH(SQW)) eng ();

    render_sequencer #(.SQ_WIDTH(SQW), .TIMEOUT(TMO), .TO_W(TOW)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .square1     (square1),
        .square2     (square2),
        .square3     (square3),
        .sq_en       (sq_en),
        .eng         (eng),
        .busy        (busy),
        .frame_done  (frame_done),
        .timeout_err (timeout_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    cmd_t exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // engine knobs, set by the stimulus process
    int stall_cfg = 0;
    int done_dly  = 3;
    int drop_idx  = -1;

    // engine and monitor state
    int   cyc = 0;
    int   hs_count = 0;
    int   last_hs_cyc = 0;
    int   stall_n = 0;
    int   dcnt = 0;
    int   done_cyc = 0;
    logic rdy_up = 1'b0;
    logic pend = 1'b0;
    logic cap_valid = 1'b0;
    logic done_seen = 1'b0;
    cmd_t cap;
    int   fd_count = 0;
    int   ov_count = 0;
    int   to_cyc = 0;
    logic to_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural raster engine: stalls, accepts, scoreboards, then pulses done after done_dly cycles.
    always @(negedge clk) begin
        cmd_t e;
        eng.eng_done = 1'b0;
        if (rst) begin
            eng.cmd_ready = 1'b0;
            rdy_up    = 1'b0;
            stall_n   = 0;
            pend      = 1'b0;
            cap_valid = 1'b0;
            done_seen = 1'b0;
        end else begin
            if (pend) begin
                if (dcnt <= 1) begin
                    pend = 1'b0;
                    if (hs_count != drop_idx) begin
                        eng.eng_done = 1'b1;
                        done_cyc  = cyc;
                        done_seen = 1'b1;
                    end
                end else begin
                    dcnt--;
                end
            end
            if (rdy_up) begin
                rdy_up        = 1'b0;
                eng.cmd_ready = 1'b0;
                cap_valid     = 1'b0;
                stall_n       = 0;
                hs_count      = (cap.op == 1'b0) ? 1 : hs_count + 1;
                last_hs_cyc   = cyc;
                check("cmd_pending", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("cmd_op", 64'(cap.op), 64'(e.op));
                    check("cmd_square", 64'(cap.sq), 64'(e.sq));
                end
                pend = 1'b1;
                dcnt = done_dly;
            end else if (eng.cmd_valid) begin
                if (!cap_valid) begin
                    cap       = {eng.cmd_op, eng.cmd_square};
                    cap_valid = 1'b1;
                    if (eng.cmd_op && done_seen)
                        check("done_to_valid", 64'(cyc - done_cyc), 64'd1);
                    done_seen = 1'b0;
                end else begin
                    check("stall_op", 64'(eng.cmd_op), 64'(cap.op));
                    check("stall_square", 64'(eng.cmd_square), 64'(cap.sq));
                end
                if (stall_n < stall_cfg) stall_n++;
                else begin
                    eng.cmd_ready = 1'b1;
                    rdy_up        = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (frame_done) fd_count++;
        if (overrun) ov_count++;
        if (timeout_err && !to_prev) to_cyc = cyc;
        to_prev = timeout_err;
    end

    function automatic logic [SQW-1:0] mk(input logic [7:0] cy, input logic [7:0] r);
        logic [7:0] cx = 8'($urandom);
        logic [7:0] h  = 8'($urandom);
        logic [8:0] c  = 9'($urandom);
        return {c, h, r, cy, cx};
    endfunction

    // Painter's-order model: stable insertion sort of the live squares by cy.
    task automatic push_frame(input logic [SQW-1:0] a, input logic [SQW-1:0] b,
                              input logic [SQW-1:0] c, input logic [2:0] en, input int max_cmds);
        logic [SQW-1:0] s[3];
        int   idx[$];
        int   t;
        cmd_t all[$];
        s[0] = a; s[1] = b; s[2] = c;
        for (int i = 0; i < 3; i++)
            if (en[i] && s[i][23:16] != 8'd0) idx.push_back(i);
        for (int x = 1; x < idx.size(); x++)
            for (int y = x; y > 0 && s[idx[y-1]][15:8] > s[idx[y]][15:8]; y--) begin
                t = idx[y]; idx[y] = idx[y-1]; idx[y-1] = t;
            end
        all.push_back({1'b0, {SQW{1'b0}}});
        foreach (idx[i]) all.push_back({1'b1, s[idx[i]]});
        for (int i = 0; i < all.size() && i < max_cmds; i++) exp_q.push_back(all[i]);
    endtask

    int fd_base, ov_base;

    task automatic start_frame(input logic [SQW-1:0] a, input logic [SQW-1:0] b,
                               input logic [SQW-1:0] c, input logic [2:0] en, input int max_cmds);
        push_frame(a, b, c, en, max_cmds);
        fd_base = fd_count;
        ov_base = ov_count;
        @(negedge clk);
        square1 = a; square2 = b; square3 = c; sq_en = en;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        square1 = SQW'({$urandom, $urandom});
        square2 = SQW'({$urandom, $urandom});
        square3 = SQW'({$urandom, $urandom});
        sq_en   = 3'($urandom);
    endtask

    task automatic finish_frame(input string tag, input int exp_done, input logic exp_to);
        int n = 0;
        while (busy && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_bound"}, 64'(n < LIMIT), 64'd1);
        repeat (3) @(negedge clk);
        check({tag, "_frame_done"}, 64'(fd_count - fd_base), 64'(exp_done));
        check({tag, "_timeout_err"}, 64'(timeout_err), 64'(exp_to));
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_left"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    logic [SQW-1:0] a, b, c;

    initial begin
        rst = 1'b1; frame_start = 1'b0; sq_en = '0;
        square1 = '0; square2 = '0; square3 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(eng.cmd_valid), 64'd0);
        check("rst_op", 64'(eng.cmd_op), 64'd0);
        check("rst_square", 64'(eng.cmd_square), 64'd0);
        check("rst_flags", 64'({frame_done, timeout_err, overrun}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // sort order sq2, sq3, sq1 and two-cycle start latency
        a = mk(8'd40, 8'd5); b = mk(8'd10, 8'd5); c = mk(8'd25, 8'd5);
        start_frame(a, b, c, 3'b111, 99);
        check("lat_sort", 64'(eng.cmd_valid), 64'd0);
        check("lat_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check("lat_clear", 64'({eng.cmd_valid, eng.cmd_op}), 64'b10);
        finish_frame("sort", 1, 1'b0);

        // cy tie keeps index order, r=0 square skipped
        a = mk(8'd20, 8'd7); b = mk(8'd20, 8'd3); c = mk(8'd5, 8'd0);
        start_frame(a, b, c, 3'b111, 99);
        finish_frame("tie", 1, 1'b0);

        // backpressure on every command
        stall_cfg = 7;
        a = mk(8'd200, 8'd1); b = mk(8'd3, 8'd9); c = mk(8'd90, 8'd2);
        start_frame(a, b, c, 3'b101, 99);
        finish_frame("stall", 1, 1'b0);
        stall_cfg = 0;

        // empty frame: clear only
        start_frame(a, b, c, 3'b000, 99);
        finish_frame("empty", 1, 1'b0);

        // engine never finishes the first draw
        drop_idx = 2;
        a = mk(8'd40, 8'd5); b = mk(8'd10, 8'd5); c = mk(8'd25, 8'd5);
        start_frame(a, b, c, 3'b111, 2);
        finish_frame("timeout", 0, 1'b1);
        check("timeout_cycle", 64'(to_cyc - last_hs_cyc), 64'(TMO));
        drop_idx = -1;

        // next frame clears the sticky error
        start_frame(a, b, c, 3'b011, 99);
        check("err_cleared", 64'(timeout_err), 64'd0);
        finish_frame("recover", 1, 1'b0);

        // done on the last allowed wait cycle succeeds; one cycle later times out
        done_dly = 19;
        start_frame(a, b, c, 3'b110, 99);
        finish_frame("edge_ok", 1, 1'b0);
        done_dly = 20;
        start_frame(a, b, c, 3'b001, 1);
        finish_frame("edge_late", 0, 1'b1);
        check("edge_cycle", 64'(to_cyc - last_hs_cyc), 64'(TMO));
        done_dly = 3;

        // overrun during DRAW_WAIT leaves the frame intact
        done_dly = 10;
        a = mk(8'd77, 8'd4); b = mk(8'd12, 8'd4); c = mk(8'd50, 8'd4);
        start_frame(a, b, c, 3'b111, 99);
        for (int i = 0; i < LIMIT && hs_count != 2; i++) @(negedge clk);
        square1 = mk(8'd1, 8'd1);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        finish_frame("overrun", 1, 1'b0);
        check("overrun_pulses", 64'(ov_count - ov_base), 64'd1);
        done_dly = 3;

        // asynchronous reset while a draw is stalled in ISSUE
        stall_cfg = 7;
        start_frame(a, b, c, 3'b111, 99);
        for (int i = 0; i < LIMIT && !(eng.cmd_valid && eng.cmd_op); i++) @(negedge clk);
        check("issue_reached", 64'({eng.cmd_valid, eng.cmd_op}), 64'b11);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 64'(eng.cmd_valid), 64'd0);
        check("arst_op", 64'(eng.cmd_op), 64'd0);
        check("arst_square", 64'(eng.cmd_square), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_flags", 64'({frame_done, timeout_err, overrun}), 64'd0);
        @(negedge clk);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        stall_cfg = 0;
        @(negedge clk);
        a = mk(8'd9, 8'd6); b = mk(8'd8, 8'd6); c = mk(8'd7, 8'd6);
        start_frame(a, b, c, 3'b111, 99);
        finish_frame("post_rst", 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
